// File: rtl/wasm_prog_loader_pkg.sv
// Shared types and defaults for the WASM instruction-BRAM program loader.
package wasm_prog_loader_pkg;

  localparam int          DEF_ADDR_W  = 10;
  localparam int          DEF_DATA_W  = 8;
  localparam logic [31:0] DEF_TIMEOUT = 32'd100000;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_RUN  = 2'd2,
    LDR_DONE = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/wasm_prog_loader.sv
// Streams a program image into the core's instruction BRAM, releases the core and supervises the run.
// Optional: define WASM_LOADER_CYCLE_CNT_EN to expose the RUN cycle count on o_cycle_cnt.
module wasm_prog_loader
  import wasm_prog_loader_pkg::*;
#(
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          DATA_W  = DEF_DATA_W,
  parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_core_rst_n,
  input  logic              i_instr_finish,
  input  logic              i_instr_error,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic              o_timeout,
  output logic              o_err
`ifdef WASM_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]       o_cycle_cnt
`endif
);

  ldr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       wdog;
  logic              at_end;
  logic              wd_exp;

  assign at_end      = (cnt == {ADDR_W{1'b1}});
  assign wd_exp      = (TIMEOUT != 32'd0) && (wdog == TIMEOUT - 32'd1);
  assign o_bram_addr = cnt;

`ifdef WASM_LOADER_CYCLE_CNT_EN
  // The watchdog counts every RUN cycle and freezes outside RUN, so it doubles as the run length.
  assign o_cycle_cnt = wdog;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LDR_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_ready      = 1'b0;
    o_bram_we    = 1'b0;
    o_bram_wdata = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      LDR_IDLE: if (i_start) state_nxt = LDR_LOAD;
      LDR_LOAD: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_valid) begin
          o_bram_we    = 1'b1;
          o_bram_wdata = i_data;
          if (i_last)      state_nxt = LDR_RUN;
          else if (at_end) state_nxt = LDR_DONE;
        end
      end
      LDR_RUN: begin
        o_busy = 1'b1;
        if (i_instr_error || i_instr_finish || wd_exp) state_nxt = LDR_DONE;
      end
      LDR_DONE: begin
        o_done = 1'b1;
        if (i_start) state_nxt = LDR_LOAD;
      end
      default: state_nxt = LDR_IDLE;
    endcase
  end

  // Counter, watchdog and sticky status; the core stays released after finish/error for inspection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      wdog         <= '0;
      o_ovf        <= 1'b0;
      o_timeout    <= 1'b0;
      o_err        <= 1'b0;
      o_core_rst_n <= 1'b0;
    end else begin
      case (state)
        LDR_IDLE, LDR_DONE: begin
          if (i_start) begin
            cnt          <= '0;
            wdog         <= '0;
            o_ovf        <= 1'b0;
            o_timeout    <= 1'b0;
            o_err        <= 1'b0;
            o_core_rst_n <= 1'b0;
          end
        end
        LDR_LOAD: begin
          if (i_valid) begin
            if (!at_end) cnt <= cnt + ADDR_W'(1);
            if (i_last)      o_core_rst_n <= 1'b1;
            else if (at_end) o_ovf        <= 1'b1;
          end
        end
        LDR_RUN: begin
          wdog <= wdog + 32'd1;
          if (i_instr_error) begin
            o_err <= 1'b1;
          end else if (!i_instr_finish && wd_exp) begin
            o_timeout    <= 1'b1;
            o_core_rst_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_prog_loader.sv
// Bench for wasm_prog_loader: directed scenarios plus randomized loads/runs against a behavioural model.
module tb_wasm_prog_loader;

  localparam int          AW    = 3;
  localparam int          DW    = 8;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TO    = 32'd16;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0, i_valid = 1'b0, i_last = 1'b0;
  logic          i_instr_finish = 1'b0, i_instr_error = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready, o_bram_we, o_core_rst_n, o_busy, o_done, o_ovf, o_timeout, o_err;
  logic [AW-1:0] o_bram_addr;
  logic [DW-1:0] o_bram_wdata;
`ifdef WASM_LOADER_CYCLE_CNT_EN
  logic [31:0]   o_cycle_cnt;
`endif

  wasm_prog_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_wdata(o_bram_wdata), .o_core_rst_n(o_core_rst_n), .i_instr_finish(i_instr_finish),
    .i_instr_error(i_instr_error), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf),
    .o_timeout(o_timeout), .o_err(o_err)
`ifdef WASM_LOADER_CYCLE_CNT_EN
    , .o_cycle_cnt(o_cycle_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the load/run sequence plus the observable status it implies.
  int m_ph = P_IDLE, m_addr = 0, m_run = 0;
  bit m_ovf = 0, m_tmo = 0, m_err = 0, m_rel = 0;
  logic [15:0] wlog[$];

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_ph = P_IDLE; m_addr = 0; m_run = 0;
      m_ovf = 0; m_tmo = 0; m_err = 0; m_rel = 0;
    end else begin
      case (m_ph)
        P_IDLE, P_DONE: if (i_start) begin
          m_ph = P_LOAD; m_addr = 0; m_run = 0;
          m_ovf = 0; m_tmo = 0; m_err = 0; m_rel = 0;
        end
        P_LOAD: if (i_valid) begin
          if (i_last) begin
            m_ph = P_RUN; m_rel = 1;
          end else if (m_addr == DEPTH - 1) begin
            m_ovf = 1; m_ph = P_DONE;
          end
          m_addr++;
        end
        P_RUN: begin
          m_run++;
          if (i_instr_error) begin
            m_err = 1; m_ph = P_DONE;
          end else if (i_instr_finish) begin
            m_ph = P_DONE;
          end else if (TO != 0 && m_run == int'(TO)) begin
            m_tmo = 1; m_rel = 0; m_ph = P_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      bit exp_we;
      exp_we = (m_ph == P_LOAD) && i_valid;
      chk("ready", o_ready, m_ph == P_LOAD);
      chk("bram_we", o_bram_we, exp_we);
      if (exp_we || m_ph == P_IDLE) chk("bram_addr", o_bram_addr, m_addr);
      if (exp_we) chk("bram_wdata", o_bram_wdata, i_data);
      else if (m_ph == P_IDLE) chk("bram_wdata", o_bram_wdata, 0);
      chk("core_rst_n", o_core_rst_n, m_rel);
      chk("busy", o_busy, (m_ph == P_LOAD) || (m_ph == P_RUN));
      chk("done", o_done, m_ph == P_DONE);
      chk("ovf", o_ovf, m_ovf);
      chk("timeout", o_timeout, m_tmo);
      chk("err", o_err, m_err);
`ifdef WASM_LOADER_CYCLE_CNT_EN
      chk("cycle_cnt", o_cycle_cnt, m_run);
`endif
    end
    if (o_bram_we === 1'b1) wlog.push_back({5'b0, o_bram_addr, o_bram_wdata});
  end

  // Applies inputs for the current cycle, advances one clock, then parks inputs idle.
  task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit l,
                       input bit f, input bit e, input bit r);
    i_start = st; i_valid = v; i_data = d; i_last = l;
    i_instr_finish = f; i_instr_error = e; i_rst = r;
    @(posedge i_clk); #2;
    i_start = 0; i_valid = 0; i_data = '0; i_last = 0;
    i_instr_finish = 0; i_instr_error = 0; i_rst = 0;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  logic [7:0] img[4] = '{8'h41, 8'h6A, 8'h20, 8'h0B};

  initial begin
    int b, n, len, fin_at, sent;
    bit use_err, v;

    drive(0, 0, 8'h00, 0, 0, 0, 1);
    chk_en = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0, 1);
    // Reset state
    chk("rst_outputs", {o_ready, o_bram_we, o_core_rst_n, o_busy, o_done, o_ovf, o_timeout, o_err}, 0);
    chk("rst_addr", o_bram_addr, 0);

    // Four-byte image, finish on the 10th RUN cycle
    b = wlog.size();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, img[k], k == 3, 0, 0, 0);
    chk("t1_nwrites", wlog.size() - b, 4);
    for (int k = 0; k < 4; k++) chk("t1_write", wlog[b+k], {8'(k), img[k]});
    chk("t1_released", o_core_rst_n, 1);
    repeat (9) idle();
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    chk("t1_done", o_done, 1);
    chk("t1_core_kept", o_core_rst_n, 1);
`ifdef WASM_LOADER_CYCLE_CNT_EN
    chk("t1_cycles", o_cycle_cnt, 10);
`endif

    // Gapped stream: valid every other cycle, 6 beats
    b = wlog.size();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) drive(0, k % 2 == 0, 8'(8'h90 + k), k == 10, 0, 0, 0);
    chk("t2_nwrites", wlog.size() - b, 6);
    for (int k = 0; k < 6; k++) chk("t2_addr", wlog[b+k][15:8], k);
    drive(0, 0, 8'h00, 0, 1, 0, 0);

    // Overflow: 9 beats, no last, into an 8-deep BRAM
    b = wlog.size();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) drive(0, 1, 8'(k), 0, 0, 0, 0);
    chk("ovf_nwrites", wlog.size() - b, 8);
    chk("ovf_flag", o_ovf, 1);
    chk("ovf_done", o_done, 1);
    chk("ovf_ready", o_ready, 0);
    chk("ovf_core_held", o_core_rst_n, 0);

    // Watchdog: count released RUN cycles until timeout
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    drive(0, 1, 8'h55, 1, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_timeout) break;
      if (o_core_rst_n) n++;
      idle();
    end
    chk("tmo_run_cycles", n, 16);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_core_held", o_core_rst_n, 0);

    // Error and finish together: error wins, then start clears flags
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    drive(0, 1, 8'h01, 0, 0, 0, 0);
    drive(0, 1, 8'h02, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 1, 0);
    chk("ef_err", o_err, 1);
    chk("ef_done", o_done, 1);
    chk("ef_core_kept", o_core_rst_n, 1);
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    chk("ef_cleared", {o_err, o_done, o_timeout, o_ovf}, 0);
    chk("ef_reload", o_ready, 1);

    // Reset mid-load, then a fresh load from address 0
    drive(0, 1, 8'hA0, 0, 0, 0, 0);
    drive(0, 1, 8'hA1, 0, 0, 0, 1);
    chk("rst_mid_outputs", {o_ready, o_bram_we, o_core_rst_n, o_busy, o_done, o_ovf, o_timeout, o_err}, 0);
    chk("rst_mid_addr", o_bram_addr, 0);
    b = wlog.size();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 8'(8'hC0 + k), k == 2, 0, 0, 0);
    for (int k = 0; k < 3; k++) chk("rst_reload", wlog[b+k], {8'(k), 8'(8'hC0 + k)});
    drive(0, 0, 8'h00, 0, 1, 0, 0);

    // Randomized loads and runs with spurious starts, ignored events and occasional resets
    for (int it = 0; it < 40; it++) begin
      len     = $urandom_range(1, 10);
      fin_at  = $urandom_range(0, 20);
      use_err = ($urandom_range(0, 3) == 0);
      drive(1, $urandom_range(0, 1) == 1, 8'($urandom), 0, 0, 0, 0);
      sent = 0; n = 0;
      while (m_ph == P_LOAD && n < 100) begin
        v = ($urandom_range(0, 3) != 0);
        drive($urandom_range(0, 9) == 0, v, 8'($urandom), v && sent == len - 1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
        if (v) sent++;
        n++;
      end
      n = 0;
      while (m_ph == P_RUN && n < 100) begin
        drive($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 8'($urandom), 0,
              n == fin_at, use_err && n == fin_at, 0);
        n++;
      end
      if (n >= 100) chk("rand_run_bound", 0, 1);
      repeat ($urandom_range(0, 2)) drive(0, $urandom_range(0, 1) == 1, 8'($urandom), 0, 1, 1, 0);
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
